clock_rate_monitor: RTL and testbench

//  Measures the frequency of a slow clock or toggling signal (e.g. the divided design clock)

---
 rtl/clock_rate_monitor.sv | 122 ++++++++++++
 tb/tb_clock_rate_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clock_rate_monitor.sv
// clock_rate_monitor
//   Counts rising edges of an asynchronous signal (meas_in) over a fixed gate
//   window of GATE_CYCLES CLK cycles and publishes the result once per window.
//   Windows run back to back while enable is high, with no dead cycle between them.
// Ports
//   CLK          board clock, sole clock
//   RESET        synchronous, active-high reset
//   meas_in      signal under measurement (asynchronous to CLK)
//   enable       1 = run windows back to back, 0 = idle
//   count        rising edges seen in the last completed window (saturating)
//   count_valid  one-cycle strobe when count/in_range/overflow update
//   in_range     EXP_MIN <= count <= EXP_MAX for the last window
//   overflow     last window saturated the edge counter
module clock_rate_monitor #(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_MIN     = 0,
  parameter int EXP_MAX     = 65535
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             meas_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             overflow
);

  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(EXP_MAX);

  typedef enum logic {IDLE, MEASURE} state_t;
  state_t state, state_nxt;

  // Synchronizer plus one history flop; runs in every state so a level
  // already high at re-enable is not mistaken for a fresh edge.
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   rise;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], meas_in};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;

  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic             terminal;
  logic             at_max;
  logic             sat_hit;
  logic [CNT_W-1:0] edge_sum;
  logic             range_nxt;

  assign terminal = (state == MEASURE) && (gate_cnt == GATE_LAST);
  assign at_max   = (edge_cnt == CNT_MAX);
  assign sat_hit  = rise & at_max;
  assign edge_sum = edge_cnt + CNT_W'(rise & ~at_max);
  // int compare avoids a constant-zero unsigned compare when EXP_MIN is 0;
  // both sides are zero-extended CNT_W values, so it is still unsigned.
  assign range_nxt = (int'(edge_sum) >= int'(MIN_V)) && (int'(edge_sum) <= int'(MAX_V));

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Dropping enable leaves MEASURE whether or not this is the terminal
  // cycle; the terminal window still publishes in the datapath below.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = MEASURE;
      MEASURE: if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      sat         <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (state == MEASURE && enable && !terminal) begin
        gate_cnt <= gate_cnt + GW'(1);
        edge_cnt <= edge_sum;
        sat      <= sat | sat_hit;
      end else begin
        // idle, aborted window, or window boundary: start the next one clean
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end
      if (terminal) begin
        // a rise on the terminal cycle belongs to the closing window
        count       <= edge_sum;
        overflow    <= sat | sat_hit;
        in_range    <= range_nxt;
        count_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_rate_monitor.sv
// Self-checking bench for clock_rate_monitor: randomized/patterned meas_in,
// a window-level reference model, and a scoreboard monitor on count_valid.
module tb_clock_rate_monitor;

  localparam int GATE = 256;
  localparam int CW   = 6;
  localparam int EMIN = 15;
  localparam int EMAX = 17;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          meas_in = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] count;
  logic          count_valid;
  logic          in_range;
  logic          overflow;

  clock_rate_monitor #(
    .GATE_CYCLES(GATE), .CNT_W(CW), .SYNC_STAGES(2), .EXP_MIN(EMIN), .EXP_MAX(EMAX)
  ) dut (
    .CLK(CLK), .RESET(RESET), .meas_in(meas_in), .enable(enable),
    .count(count), .count_valid(count_valid), .in_range(in_range), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // ---------------- reference model ----------------
  typedef struct {int cnt; bit ovf; bit rng; int at_n;} exp_t;
  exp_t q[$];

  int n = 0;                       // posedge index
  bit s0 = 0, s1 = 0, s2 = 0;      // meas_in as sampled 1, 2, 3 edges ago
  bit active = 0;
  int start = 0;
  int acc = 0;                     // unbounded edge count of the open window
  bit exp_valid = 0;
  int pub_cnt = 0;
  bit pub_ovf = 0, pub_rng = 0;

  // A transition sampled at edge k passes the 2-flop synchronizer and is
  // counted by the window at edge k+2. The window opened at edge `start`
  // owns the rises counted at edges start+1 .. start+GATE.
  initial forever begin
    bit r;
    exp_t e;
    @(posedge CLK);
    n++;
    r = s1 & ~s2;
    s2 = s1; s1 = s0; s0 = meas_in;
    exp_valid = 0;
    if (RESET) begin
      s0 = 0; s1 = 0; s2 = 0;
      active = 0;
      pub_cnt = 0; pub_ovf = 0; pub_rng = 0;
    end else if (!active) begin
      if (enable) begin active = 1; start = n; acc = 0; end
    end else begin
      acc += int'(r);
      if (n - start == GATE) begin
        e.cnt  = (acc > CMAX) ? CMAX : acc;
        e.ovf  = (acc > CMAX);
        e.rng  = (e.cnt >= EMIN) && (e.cnt <= EMAX);
        e.at_n = n;
        q.push_back(e);
        pub_cnt = e.cnt; pub_ovf = e.ovf; pub_rng = e.rng;
        exp_valid = 1;
        if (enable) begin start = n; acc = 0; end
        else active = 0;
      end else if (!enable) begin
        active = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (count_valid !== exp_valid) begin
      chk(0, "strobe", $sformatf("cycle %0d count_valid=%0b want %0b", n, count_valid, exp_valid));
    end else if (count_valid) begin
      if (q.size() == 0) begin
        chk(0, "scoreboard", $sformatf("cycle %0d strobe with empty queue", n));
      end else begin
        e = q.pop_front();
        chk(int'(count) == e.cnt && overflow == e.ovf && in_range == e.rng && n == e.at_n,
            "window",
            $sformatf("cycle %0d got cnt=%0d ovf=%0b rng=%0b, want cnt=%0d ovf=%0b rng=%0b at cycle %0d",
                      n, count, overflow, in_range, e.cnt, e.ovf, e.rng, e.at_n));
      end
    end else begin
      chk(int'(count) == pub_cnt && overflow == pub_ovf && in_range == pub_rng, "hold",
          $sformatf("cycle %0d got cnt=%0d ovf=%0b rng=%0b, want cnt=%0d ovf=%0b rng=%0b",
                    n, count, overflow, in_range, pub_cnt, pub_ovf, pub_rng));
    end
  end

  // ---------------- meas_in generator ----------------
  // mode 0/1: hold level, 2: square wave with half period hp, 3: random, 4: manual
  int mode = 0;
  int hp = 8;
  bit man = 0;

  initial forever begin
    int ph;
    @(negedge CLK);
    #1;
    case (mode)
      0: meas_in = 1'b0;
      1: meas_in = 1'b1;
      2: begin ph++; if (ph >= hp) begin ph = 0; meas_in = ~meas_in; end end
      3: meas_in = 1'($urandom_range(0, 1));
      default: meas_in = man;
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge CLK);
  endtask

  // wait until the model's open window has run `ph` edges
  task automatic wait_phase(input int ph);
    int guard = 0;
    while (!(active && n - start == ph) && guard < 4 * GATE) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 4 * GATE) chk(0, "wait_phase", $sformatf("phase %0d never reached", ph));
  endtask

  initial begin
    tick(3);
    RESET = 1'b0;
    tick(2);

    // CLK/16 square wave, back-to-back windows
    mode = 2; hp = 8; enable = 1'b1;
    tick(GATE * 3 + 10);

    // held low, then held high
    mode = 0; tick(GATE * 2);
    mode = 1; tick(GATE * 2);

    // single pulse counted on the terminal cycle, then one cycle later
    man = 0; mode = 4; tick(GATE + 5);
    wait_phase(GATE - 3); man = 1; tick(3); man = 0;
    tick(GATE);
    wait_phase(GATE - 2); man = 1; tick(3); man = 0;
    tick(GATE + 5);

    // toggle every CLK saturates, then slow wave recovers
    mode = 2; hp = 1; tick(GATE * 2);
    hp = 32; tick(GATE * 2 + 5);

    // enable dropped mid-window, then re-enabled
    hp = 8;
    wait_phase(100); enable = 1'b0; tick(50);
    enable = 1'b1; tick(GATE * 2 + 5);

    // reset mid-window
    wait_phase(120); RESET = 1'b1; tick(1); RESET = 1'b0;
    tick(GATE * 2 + 5);

    // enable dropped exactly on the terminal cycle: window still publishes
    wait_phase(GATE - 1); enable = 1'b0; tick(5);
    enable = 1'b1; tick(GATE + 5);

    // random input with occasional enable toggles
    mode = 3;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 399) == 0) enable = ~enable;
    end
    enable = 1'b1; mode = 2; hp = 3; tick(GATE + 5);

    enable = 1'b0; tick(5);
    chk(q.size() == 0, "drain", $sformatf("%0d expected windows never published", q.size()));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
